// File: rtl/io_loopback_check.sv
// Loopback checker for one header: compares synchronized pin readback against the
// generator's pattern after each toggle. Optional stop-on-first-fail: IO_CHECK_STOP_ON_FAIL_EN.
module io_loopback_check #(
    parameter int WIDTH      = 34,
    parameter int SETTLE     = 16,
    parameter int NUM_CHECKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] exp_io,
    input  logic [WIDTH-1:0] rx_io,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] fail_mask,
    output logic [15:0]      err_cnt,
    output logic [15:0]      chk_cnt,
    output logic [2:0]       state_dbg
);

    // start is a single-cycle request with no ready/ack: it is accepted only in
    // IDLE or DONE (busy=0) and silently dropped while busy=1.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE - 1);
    localparam logic [15:0] LAST_CHECK  = 16'(NUM_CHECKS - 1);

    state_t           state;
    logic [WIDTH-1:0] rx_meta;
    logic [WIDTH-1:0] rx_s;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_snap;
    logic [15:0]      cnt;

    logic             edge_det;
    logic [WIDTH-1:0] mism;
    logic [WIDTH-1:0] mask_next;
    logic             any_mism;
    logic [15:0]      err_next;
    logic             last_check;

    assign edge_det  = (exp_io != exp_q);
    assign mism      = rx_s ^ exp_snap;
    assign mask_next = fail_mask | mism;
    assign any_mism  = |mism;
    assign err_next  = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
`ifdef IO_CHECK_STOP_ON_FAIL_EN
    assign last_check = (chk_cnt == LAST_CHECK) || any_mism;
`else
    assign last_check = (chk_cnt == LAST_CHECK);
`endif
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rx_meta   <= '0;
            rx_s      <= '0;
            exp_q     <= '0;
            exp_snap  <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_cnt   <= '0;
            chk_cnt   <= '0;
        end else begin
            rx_meta <= rx_io;
            rx_s    <= rx_meta;
            exp_q   <= exp_io;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        fail_mask <= '0;
                        err_cnt   <= '0;
                        chk_cnt   <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (edge_det) begin
                        exp_snap <= exp_io;
                        cnt      <= SETTLE_LOAD;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // A toggle inside the window restarts it on the newer pattern.
                    if (edge_det) begin
                        exp_snap <= exp_io;
                        cnt      <= SETTLE_LOAD;
                    end else if (cnt == 16'd0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_CHECK: begin
                    fail_mask <= mask_next;
                    chk_cnt   <= chk_cnt + 16'd1;
                    if (any_mism) begin
                        err_cnt <= err_next;
                    end
                    if (last_check) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (mask_next == '0);
                        state <= S_DONE;
                    end else begin
                        state <= S_ARM;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_loopback_check.sv
// Directed bench for io_loopback_check (WIDTH=34, SETTLE=4, NUM_CHECKS=4).
module tb_io_loopback_check;

    localparam int W = 34;

`ifdef IO_CHECK_STOP_ON_FAIL_EN
    localparam int STUCK_CHK = 1;
    localparam int STUCK_ERR = 1;
    localparam int EDGE_CHK  = 3;
`else
    localparam int STUCK_CHK = 4;
    localparam int STUCK_ERR = 2;
    localparam int EDGE_CHK  = 4;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] exp_io = '0;
    logic [W-1:0] rx_io = '0;
    logic         busy;
    logic         done;
    logic         pass;
    logic [W-1:0] fail_mask;
    logic [15:0]  err_cnt;
    logic [15:0]  chk_cnt;
    logic [2:0]   state_dbg;

    logic [W-1:0] exp_next = '0;
    logic [W-1:0] rx_stuck0 = '0;
    logic         rx_freeze = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;

    io_loopback_check #(.WIDTH(W), .SETTLE(4), .NUM_CHECKS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_io(exp_io), .rx_io(rx_io),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt), .state_dbg(state_dbg)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, need finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // One cycle of the loopback fixture: pins follow the pattern one cycle late.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rx_freeze) rx_io = exp_io & ~rx_stuck0;
            exp_io = exp_next;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic toggle_run(input int toggles);
        for (int k = 0; k < toggles; k++) begin
            exp_next = ~exp_next;
            tick(20);
        end
    endtask

    initial begin
        tick(3);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_pass", W'(pass), '0);
        check("rst_mask", fail_mask, '0);
        check("rst_err", W'(err_cnt), '0);
        check("rst_chk", W'(chk_cnt), '0);
        check("rst_state", W'(state_dbg), W'(0));
        rst = 1'b0;
        tick(3);

        // Clean loopback
        pulse_start();
        check("clean_busy_start", W'(busy), W'(1));
        tick(5);
        toggle_run(2);
        check("clean_mid_chk", W'(chk_cnt), W'(2));
        check("clean_mid_busy", W'(busy), W'(1));
        toggle_run(2);
        check("clean_done", W'(done), W'(1));
        check("clean_busy", W'(busy), W'(0));
        check("clean_pass", W'(pass), W'(1));
        check("clean_mask", fail_mask, '0);
        check("clean_err", W'(err_cnt), W'(0));
        check("clean_chk", W'(chk_cnt), W'(4));
        check("clean_state", W'(state_dbg), W'(4));

        // Stuck-at-0 pin 5
        rx_stuck0 = W'(34'h20);
        pulse_start();
        check("stuck_restart_chk", W'(chk_cnt), W'(0));
        check("stuck_restart_done", W'(done), W'(0));
        tick(5);
        toggle_run(4);
        check("stuck_done", W'(done), W'(1));
        check("stuck_pass", W'(pass), W'(0));
        check("stuck_mask", fail_mask, W'(34'h0_0000_0020));
        check("stuck_err", W'(err_cnt), W'(STUCK_ERR));
        check("stuck_chk", W'(chk_cnt), W'(STUCK_CHK));

        // Asynchronous reset mid-run
        pulse_start();
        tick(5);
        toggle_run(2);
        check("mid_pre_mask", fail_mask, W'(34'h20));
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_done", W'(done), '0);
        check("mid_rst_mask", fail_mask, '0);
        check("mid_rst_err", W'(err_cnt), '0);
        check("mid_rst_chk", W'(chk_cnt), '0);
        check("mid_rst_state", W'(state_dbg), W'(0));
        @(negedge clk);
        rst = 1'b0;
        rx_stuck0 = '0;
        tick(3);
        pulse_start();
        tick(5);
        toggle_run(4);
        check("post_rst_pass", W'(pass), W'(1));
        check("post_rst_chk", W'(chk_cnt), W'(4));

        // Start while busy, edges inside the settle window
        pulse_start();
        tick(5);
        exp_next = ~exp_next;
        tick(2);
        pulse_start();
        check("busy_start_state", W'(state_dbg), W'(2));
        check("busy_start_chk", W'(chk_cnt), W'(0));
        check("busy_start_busy", W'(busy), W'(1));
        tick(10);
        check("busy_start_after", W'(chk_cnt), W'(1));

        exp_next = W'(34'h2_AAAA_AAAA);
        tick(2);
        exp_next = W'(34'h1_5555_5555);
        tick(1);
        tick(5);
        check("restart_not_yet", W'(chk_cnt), W'(1));
        tick(1);
        check("restart_chk", W'(chk_cnt), W'(2));
        check("restart_err", W'(err_cnt), W'(0));
        check("restart_mask", fail_mask, '0);

        tick(10);
        exp_next = W'(34'h0_0000_FFFF);
        tick(2);
        rx_freeze = 1'b1;
        exp_next = W'(34'h0_00FF_FFFF);
        tick(1);
        tick(6);
        check("stale_rx_chk", W'(chk_cnt), W'(3));
        check("stale_rx_err", W'(err_cnt), W'(1));
        check("stale_rx_mask", fail_mask, W'(34'h0_00FF_0000));
        rx_freeze = 1'b0;
        tick(10);
        exp_next = '0;
        tick(20);
        check("edge_done", W'(done), W'(1));
        check("edge_pass", W'(pass), W'(0));
        check("edge_chk", W'(chk_cnt), W'(EDGE_CHK));
        check("edge_err", W'(err_cnt), W'(1));

        // Start from DONE clears status
        pulse_start();
        check("done_start_busy", W'(busy), W'(1));
        check("done_start_done", W'(done), W'(0));
        check("done_start_chk", W'(chk_cnt), W'(0));
        check("done_start_err", W'(err_cnt), W'(0));
        check("done_start_mask", fail_mask, '0);
        check("done_start_state", W'(state_dbg), W'(1));

        rst = 1'b1;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_loopback_check.md
Name: io_loopback_check

Overview:
- Downstream checker for the header IO toggle generator. It consumes the generator's driven pattern (exp_io) and the same header pins read back through a loopback fixture (rx_io).
- After each pattern toggle it waits a settle window, then compares synchronized readback against the expected pattern.
- Accumulates a sticky per-pin fail mask and error/check counters over a fixed number of toggles, then reports pass/fail.
- One instance per header (J3/J4/J6/J7).

Parameters:
- WIDTH, 34, pins per header.
- SETTLE, 16, cycles from toggle detection to sample (legal range 3..65535).
- NUM_CHECKS, 8, toggles compared per run (legal range 1..65535).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a run when not busy.
- exp_io  input  WIDTH  expected pattern, synchronous to clk (generator output).
- rx_io  input  WIDTH  looped-back pins, asynchronous.
- busy  output  1  run in progress.
- done  output  1  run finished; level, held until next start or reset.
- pass  output  1  valid when done=1; 1 = no mismatches.
- fail_mask  output  WIDTH  sticky; bit i set if pin i ever mismatched this run.
- err_cnt  output  16  checks with at least one mismatch, saturating at 0xFFFF.
- chk_cnt  output  16  checks performed this run.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is asynchronous, active-high.
  - rst=1 forces: state IDLE; busy=0, done=0, pass=0, fail_mask=0, err_cnt=0, chk_cnt=0; synchronizer flops=0; exp_q=0; settle counter=0.
- Input capture:
  - rx_io passes through a 2-flop synchronizer per bit, giving rx_s.
  - exp_q <= exp_io every cycle.
  - edge = (exp_io != exp_q), combinational.
- FSM states: IDLE, ARM, SETTLE, CHECK, DONE. busy=1 in ARM, SETTLE and CHECK.
- IDLE / DONE:
  - start=1 clears fail_mask, err_cnt, chk_cnt, done and pass, then moves to ARM next cycle.
  - DONE holds done=1 and the final pass value.
- ARM:
  - On edge: snapshot exp_snap <= exp_io, load cnt <= SETTLE-1, go to SETTLE.
  - An edge present in the same cycle as the start pulse is not armed.
- SETTLE:
  - cnt decrements each cycle.
  - If edge occurs, re-snapshot exp_io and reload cnt <= SETTLE-1; the restart is not counted as a check.
  - When cnt==0 and no edge, go to CHECK.
- CHECK (one cycle):
  - mism = rx_s ^ exp_snap.
  - fail_mask <= fail_mask | mism.
  - If mism != 0, err_cnt increments (saturating).
  - chk_cnt increments.
  - If chk_cnt+1 == NUM_CHECKS, go to DONE with pass <= ((fail_mask|mism)==0) and done <= 1. Otherwise go to ARM.
  - An edge during CHECK is missed. The generator period must exceed SETTLE+2.
- Latency: for an edge detected in cycle t, the comparison happens in cycle t+SETTLE+1; status updates are visible at t+SETTLE+2.
- start while busy=1 is ignored; no restart and no counter change.
- Reset mid-run aborts immediately to reset values; no partial result is retained.
- Counter rule: chk_cnt never exceeds NUM_CHECKS; err_cnt never exceeds chk_cnt.

Optional Feature:
- Macro: IO_CHECK_STOP_ON_FAIL_EN.
- Defined: a CHECK with mism != 0 goes directly to DONE with pass=0, regardless of chk_cnt. fail_mask, err_cnt=chk_cnt's error, and chk_cnt reflect that check.
- Undefined: all NUM_CHECKS checks always run; mismatches only accumulate.

Test Plan:
- Clean loopback: WIDTH=34, SETTLE=4, NUM_CHECKS=4; rx_io=exp_io delayed 1 cycle; exp_io toggles 0 <-> all-ones every 20 cycles; pulse start. Expect done=1 after the 4th toggle, pass=1, fail_mask=0, err_cnt=0, chk_cnt=4.
- Stuck pin: same setup, rx_io[5] tied 0, first toggle goes to all-ones. Expect fail_mask=0x0_0000_0020, err_cnt=2, chk_cnt=4, pass=0.
- Edge in settle:
  - Toggle exp_io twice 2 cycles apart. Expect the check to use the second pattern at second edge + SETTLE+1, and chk_cnt to increment by 1 only.
  - Repeat with rx matching only the first pattern; expect a mismatch counted.
- Start while busy: pulse start mid-SETTLE. Expect no change to counters or state. Start in DONE: counters clear and busy=1 next cycle.
- Reset mid-run: assert rst asynchronously after 2 checks with fail_mask nonzero. Expect all outputs 0 immediately and state IDLE; a subsequent clean run passes with chk_cnt=4.
- With IO_CHECK_STOP_ON_FAIL_EN, stuck pin 5. Expect done=1 after the 1st check, chk_cnt=1, err_cnt=1, fail_mask=0x20, pass=0. Without the macro, expect the stuck-pin results above.
